// File: rtl/frame_fill_responder_if.sv
// Bundle of the start/done four-phase handshakes, the pixel stream and
// the status outputs shared between the responder and its swap controller.
interface frame_fill_responder_if;
    logic       start;
    logic       start_ack;
    logic       done;
    logic       done_ack;
    logic       pattern_sel;
    logic [7:0] dout;
    logic       valid;
    logic       ready;
    logic [7:0] frame_count;
    logic       err;

    modport master (
        output start, done_ack, pattern_sel, ready,
        input  start_ack, done, dout, valid, frame_count, err
    );

    modport slave (
        input  start, done_ack, pattern_sel, ready,
        output start_ack, done, dout, valid, frame_count, err
    );
endinterface

// File: rtl/frame_fill_responder.sv
// Streams one frame of N_PIXEL generated pixels per start handshake and
// reports completion with a done handshake; stalled handshakes time out.
module frame_fill_responder #(
    parameter int unsigned N_PIXEL = 480000,
    parameter int unsigned TIMEOUT = 1000000
) (
    input logic                   clk_10M,
    input logic                   reset,
    frame_fill_responder_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ACK, FILL, DONE_REQ, DONE_REL} state_t;

    localparam logic [19:0] LAST_IDX = 20'(N_PIXEL - 1);
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 1);

    state_t      state_q;
    logic [19:0] idx_q;
    logic [23:0] tmo_q;
    logic        pat_q;
    logic        start_ack_q;
    logic        done_q;
    logic        valid_q;
    logic [7:0]  dout_q;
    logic [7:0]  frame_count_q;
    logic        err_q;

    logic [19:0] idx_d;
    logic [23:0] tmo_d;
    logic        tmo_hit;

    always_comb begin
        idx_d   = idx_q + 20'd1;
        tmo_d   = tmo_q + 24'd1;
        tmo_hit = (tmo_q == TMO_LAST);
    end

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            tmo_q         <= '0;
            pat_q         <= 1'b0;
            start_ack_q   <= 1'b0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
            dout_q        <= '0;
            frame_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    start_ack_q <= 1'b0;
                    done_q      <= 1'b0;
                    valid_q     <= 1'b0;
                    tmo_q       <= '0;
                    if (bus.start) begin
                        state_q     <= ACK;
                        start_ack_q <= 1'b1;
                    end
                end
                ACK: begin
                    if (!bus.start) begin
                        // Pixel 0 of a ramp is 0 ^ frame_count, same as flat.
                        state_q     <= FILL;
                        start_ack_q <= 1'b0;
                        valid_q     <= 1'b1;
                        idx_q       <= '0;
                        pat_q       <= bus.pattern_sel;
                        dout_q      <= frame_count_q;
                        tmo_q       <= '0;
                    end else if (tmo_hit) begin
                        state_q     <= IDLE;
                        err_q       <= 1'b1;
                        start_ack_q <= 1'b0;
                        tmo_q       <= '0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                FILL: begin
                    if (valid_q && bus.ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE_REQ;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            tmo_q   <= '0;
                        end else begin
                            idx_q  <= idx_d;
                            dout_q <= pat_q ? frame_count_q
                                            : (idx_d[7:0] ^ frame_count_q);
                        end
                    end
                end
                DONE_REQ: begin
                    if (bus.done_ack) begin
                        state_q <= DONE_REL;
                        done_q  <= 1'b0;
                        tmo_q   <= '0;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        done_q  <= 1'b0;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                DONE_REL: begin
                    if (!bus.done_ack) begin
                        state_q       <= IDLE;
                        frame_count_q <= frame_count_q + 8'd1;
                        tmo_q         <= '0;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    start_ack_q <= 1'b0;
                    done_q      <= 1'b0;
                    valid_q     <= 1'b0;
                    tmo_q       <= '0;
                end
            endcase
        end
    end

    assign bus.start_ack   = start_ack_q;
    assign bus.done        = done_q;
    assign bus.valid       = valid_q;
    assign bus.dout        = dout_q;
    assign bus.frame_count = frame_count_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_frame_fill_responder.sv
// Directed and randomized checks of frame_fill_responder against a
// pixel/frame-count reference model (N_PIXEL=4, TIMEOUT=16).
module tb_frame_fill_responder;

    localparam int N_PIX = 4;
    localparam int TMO   = 16;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    logic [7:0] exp_fc;
    logic       exp_err;

    frame_fill_responder_if bus ();

    frame_fill_responder #(.N_PIXEL(N_PIX), .TIMEOUT(TMO)) dut (
        .clk_10M (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Expected pixel k of a frame: flat repeats the frame number, ramp
    // mixes the low index byte with it.
    function automatic logic [7:0] exp_px(input logic flat, input int k,
                                          input logic [7:0] fc);
        logic [7:0] kb;
        kb = 8'(k);
        return flat ? fc : (kb ^ fc);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Raises start (if not already acked), waits for start_ack, releases
    // start and confirms FILL entry.
    task automatic do_start(input logic pat);
        int cyc;
        bus.start       = 1'b1;
        bus.pattern_sel = pat;
        cyc = 0;
        while (bus.start_ack !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("start_ack_rise", bus.start_ack, 1'b1);
        bus.start = 1'b0;
        step();
        chk("fill_entry_valid", bus.valid, 1'b1);
        chk("fill_entry_ack_low", bus.start_ack, 1'b0);
    endtask

    // rmode: 0 ready always, 1 ready toggles 1/0, 2 random ready.
    task automatic fill(input logic pat, input int rmode, input int n_stop,
                        input bit flip_pat);
        int   xfer;
        int   cyc;
        logic r;
        xfer = 0;
        cyc  = 0;
        while (xfer < n_stop && cyc < 400) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.ready = r;
            chk("fill_valid", bus.valid, 1'b1);
            chk("fill_dout", bus.dout, exp_px(pat, xfer, exp_fc));
            chk("fill_quiet", {bus.start_ack, bus.done}, 2'b00);
            if (flip_pat && xfer == 1) bus.pattern_sel = ~pat;
            step();
            cyc++;
            if (r) xfer++;
        end
        chk("fill_transfers", xfer, n_stop);
        if (n_stop == N_PIX) begin
            chk("done_after_last", bus.done, 1'b1);
            chk("valid_after_last", bus.valid, 1'b0);
        end
    endtask

    task automatic do_done(input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("done_hold", bus.done, 1'b1);
            step();
        end
        bus.done_ack = 1'b1;
        step();
        chk("done_release", bus.done, 1'b0);
        chk("fc_before_release", bus.frame_count, exp_fc);
        bus.done_ack = 1'b0;
        step();
        exp_fc = exp_fc + 8'd1;
        chk("frame_count", bus.frame_count, exp_fc);
        chk("idle_start_ack", bus.start_ack, 1'b0);
        chk("err_state", bus.err, exp_err);
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        exp_fc          = '0;
        exp_err         = 1'b0;
        reset           = 1'b1;
        bus.start       = 1'b1;
        bus.done_ack    = 1'b1;
        bus.pattern_sel = 1'b0;
        bus.ready       = 1'b1;

        // Reset with start asserted: reset must win.
        repeat (3) step();
        chk("rst_state", {bus.start_ack, bus.done, bus.valid, bus.err}, 4'b0000);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_fc", bus.frame_count, 8'h00);
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.done_ack = 1'b0;
        step();

        // Frame 1: ramp, ready always high.
        do_start(1'b0);
        fill(1'b0, 0, N_PIX, 1'b0);
        do_done(0);

        // Frame 2: ramp, ready toggling.
        do_start(1'b0);
        fill(1'b0, 1, N_PIX, 1'b0);
        do_done(2);

        // Frame 3: done_ack withheld -> timeout.
        do_start(1'b0);
        fill(1'b0, 0, N_PIX, 1'b0);
        for (int i = 1; i < TMO; i++) begin
            step();
            chk("tmo_done_held", bus.done, 1'b1);
            chk("tmo_err_low", bus.err, 1'b0);
        end
        step();
        exp_err = 1'b1;
        chk("tmo_err", bus.err, 1'b1);
        chk("tmo_outputs", {bus.start_ack, bus.done, bus.valid}, 3'b000);
        chk("tmo_fc", bus.frame_count, exp_fc);
        step();
        chk("tmo_idle", {bus.start_ack, bus.done, bus.valid}, 3'b000);

        // Normal frames after the timeout, err stays set.
        do_start(1'b0);
        fill(1'b0, 2, N_PIX, 1'b0);
        do_done(1);
        for (int f = 0; f < 2; f++) begin
            logic p;
            p = 1'($urandom_range(0, 1));
            do_start(p);
            fill(p, 2, N_PIX, 1'b0);
            do_done(int'($urandom_range(0, 6)));
        end

        // Flat frame at frame_count 5, pattern_sel flipped mid-frame.
        chk("fc_is_5", bus.frame_count, 8'd5);
        do_start(1'b1);
        fill(1'b1, 0, N_PIX, 1'b1);
        do_done(0);

        // start held through a whole frame: ignored until IDLE re-entry.
        do_start(1'b0);
        bus.start = 1'b1;
        fill(1'b0, 2, N_PIX, 1'b0);
        do_done(3);
        step();
        chk("restart_ack", bus.start_ack, 1'b1);
        do_start(1'b0);
        fill(1'b0, 0, N_PIX, 1'b0);
        do_done(0);

        // Reset after two transfers aborts the frame.
        do_start(1'b0);
        fill(1'b0, 0, 2, 1'b0);
        reset = 1'b1;
        step();
        chk("abort_outputs", {bus.start_ack, bus.done, bus.valid, bus.err}, 4'b0000);
        chk("abort_fc", bus.frame_count, 8'h00);
        chk("abort_dout", bus.dout, 8'h00);
        reset   = 1'b0;
        exp_fc  = '0;
        exp_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_done", bus.done, 1'b0);
        end
        do_start(1'b0);
        fill(1'b0, 0, N_PIX, 1'b0);
        do_done(0);

        // start never released -> ACK timeout, then retry succeeds.
        bus.start = 1'b1;
        step();
        chk("ack_tmo_rise", bus.start_ack, 1'b1);
        for (int i = 1; i < TMO; i++) begin
            step();
            chk("ack_tmo_held", {bus.start_ack, bus.err}, 2'b10);
        end
        step();
        exp_err = 1'b1;
        chk("ack_tmo_err", {bus.start_ack, bus.err}, 2'b01);
        chk("ack_tmo_fc", bus.frame_count, exp_fc);
        step();
        chk("ack_tmo_retry", bus.start_ack, 1'b1);
        do_start(1'b1);
        fill(1'b1, 2, N_PIX, 1'b0);
        do_done(2);

        // Random tail.
        for (int f = 0; f < 3; f++) begin
            logic p;
            p = 1'($urandom_range(0, 1));
            do_start(p);
            fill(p, 2, N_PIX, 1'b0);
            do_done(int'($urandom_range(0, 8)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
